// File: rtl/hist_mask_overlay.sv
// ============================================================================
// hist_mask_overlay
// ----------------------------------------------------------------------------
// Renders an RGB preview of the histogram-equalisation mask stream. Saturated
// pixels are painted red and contrast-masked pixels are tinted green. The
// result is buffered in a small first-word-fall-through FIFO so the display
// sink can apply backpressure. Per-frame statistics are produced for software.
//
// Optional feature macro: HIST_OVERLAY_STATS_EN
//   defined   : stats FSM, accumulators and count outputs are built.
//   undefined : mask_count, sat_count, line_count and stats_valid are tied to 0.
//
// Parameters
//   DATA_WIDTH  bits per channel (tdata is 3*DATA_WIDTH wide)
//   FIFO_DEPTH  output FIFO entries, power of two, >= 4
//   CNT_WIDTH   width of the per-frame mask/saturation counters
//
// Ports
//   i_sys_clk       system clock, rising edge
//   i_sys_areset    asynchronous active-high reset
//   en_overlay      1 = colour overlay, 0 = grey on all channels
//   clear_overflow  synchronous clear of the sticky overflow flag
//   s_axis_*        input pixel {sat mask, contrast mask, grey} + qualifiers
//   m_axis_*        output pixel {R,G,B} + qualifiers, FWFT from the FIFO
//   mask_count      contrast-mask pixels of the last completed frame
//   sat_count       saturated pixels of the last completed frame
//   line_count      tlast beats of the last completed frame
//   stats_valid     one-cycle pulse when the counts update
//   overflow        sticky: a pixel was dropped because the FIFO was full
// ============================================================================
module hist_mask_overlay #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 24
) (
   input  logic                    i_sys_clk,
   input  logic                    i_sys_areset,
   input  logic                    en_overlay,
   input  logic                    clear_overflow,
   input  logic [3*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tuser,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [3*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [CNT_WIDTH-1:0]    mask_count,
   output logic [CNT_WIDTH-1:0]    sat_count,
   output logic [15:0]             line_count,
   output logic                    stats_valid,
   output logic                    overflow
);

   localparam int PW = 3 * DATA_WIDTH;       // pixel width
   localparam int EW = PW + 2;               // FIFO entry: {tuser, tlast, rgb}
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [DATA_WIDTH-1:0] CH_ONES = '1;
   localparam logic [DATA_WIDTH-1:0] CH_ZERO = '0;
   localparam logic [DATA_WIDTH-1:0] CH_HALF = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [AW:0]           FULL_CNT = (AW+1)'(FIFO_DEPTH);

   // -------------------------------------------------------------------------
   // Input decode
   // -------------------------------------------------------------------------
   logic                  in_sat;
   logic                  in_msk;
   logic [DATA_WIDTH-1:0] grey;
   logic [DATA_WIDTH-1:0] half_grey;
   logic [PW-1:0]         rgb_next;

   assign in_sat    = (s_axis_tdata[3*DATA_WIDTH-1 -: DATA_WIDTH] == CH_ONES);
   assign in_msk    = (s_axis_tdata[2*DATA_WIDTH-1 -: DATA_WIDTH] == CH_ONES);
   assign grey      = s_axis_tdata[DATA_WIDTH-1:0];
   assign half_grey = grey >> 1;

   // Saturation wins over the mask tint. The green channel is half-scale plus
   // half the grey, so it can never exceed all-ones.
   // NOTE: every combinational output gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      rgb_next = {grey, grey, grey};
      if (en_overlay) begin
         if (in_sat)
            rgb_next = {CH_ONES, CH_ZERO, CH_ZERO};
         else if (in_msk)
            rgb_next = {half_grey, CH_HALF + half_grey, half_grey};
      end
   end

   // -------------------------------------------------------------------------
   // Colour stage register
   // -------------------------------------------------------------------------
   logic          col_valid;
   logic          col_user;
   logic          col_last;
   logic [PW-1:0] col_rgb;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset) begin
         col_valid <= 1'b0;
         col_user  <= 1'b0;
         col_last  <= 1'b0;
         col_rgb   <= '0;
      end else begin
         col_valid <= s_axis_tvalid;
         col_user  <= s_axis_tuser;
         col_last  <= s_axis_tlast;
         col_rgb   <= rgb_next;
      end
   end

   // -------------------------------------------------------------------------
   // Output FIFO (first-word-fall-through)
   // -------------------------------------------------------------------------
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          do_rd;
   logic          do_wr;
   logic          ready_en;
   logic [EW-1:0] head;

   assign full  = (count == FULL_CNT);
   assign do_rd = m_axis_tvalid & m_axis_tready;
   // A read in the same cycle frees the slot the write needs.
   assign do_wr = col_valid & (~full | do_rd);

   // NOTE: the storage array is not reset; only the pointers and count are.
   // Stale contents are never observable because the outputs are gated by
   // m_axis_tvalid, which follows the count.
   always_ff @(posedge i_sys_clk) begin
      if (do_wr)
         mem[wr_ptr] <= {col_user, col_last, col_rgb};
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ready_en <= 1'b0;
         overflow <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         // Pointers wrap naturally because FIFO_DEPTH is a power of two.
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_rd)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Setting a drop outranks a clear arriving in the same cycle.
         if (col_valid && full && !do_rd)
            overflow <= 1'b1;
         else if (clear_overflow)
            overflow <= 1'b0;
      end
   end

   // ready_en holds tready low during reset and the edge that releases it.
   assign s_axis_tready = ready_en & ~full;

   assign head          = mem[rd_ptr];
   assign m_axis_tvalid = (count != '0);
   assign m_axis_tdata  = m_axis_tvalid ? head[PW-1:0] : '0;
   assign m_axis_tlast  = m_axis_tvalid & head[PW];
   assign m_axis_tuser  = m_axis_tvalid & head[PW+1];

   // -------------------------------------------------------------------------
   // Per-frame statistics
   // -------------------------------------------------------------------------
`ifdef HIST_OVERLAY_STATS_EN
   typedef enum logic {
      WAIT_SOF = 1'b0,
      IN_FRAME = 1'b1
   } stats_state_t;

   stats_state_t         state;
   logic [CNT_WIDTH-1:0] mask_acc;
   logic [CNT_WIDTH-1:0] sat_acc;
   logic [15:0]          line_acc;

   // Counts follow the raw input stream, so FIFO drops do not affect them.
   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset) begin
         state       <= WAIT_SOF;
         mask_acc    <= '0;
         sat_acc     <= '0;
         line_acc    <= '0;
         mask_count  <= '0;
         sat_count   <= '0;
         line_count  <= '0;
         stats_valid <= 1'b0;
      end else begin
         stats_valid <= 1'b0;
         case (state)
            WAIT_SOF: begin
               if (s_axis_tvalid && s_axis_tuser) begin
                  mask_acc <= CNT_WIDTH'(in_msk);
                  sat_acc  <= CNT_WIDTH'(in_sat);
                  line_acc <= 16'(s_axis_tlast);
                  state    <= IN_FRAME;
               end
            end
            IN_FRAME: begin
               if (s_axis_tvalid) begin
                  if (s_axis_tuser) begin
                     // Frame boundary: publish the finished frame and start
                     // the new one with the current pixel's contribution.
                     mask_count  <= mask_acc;
                     sat_count   <= sat_acc;
                     line_count  <= line_acc;
                     stats_valid <= 1'b1;
                     mask_acc    <= CNT_WIDTH'(in_msk);
                     sat_acc     <= CNT_WIDTH'(in_sat);
                     line_acc    <= 16'(s_axis_tlast);
                  end else begin
                     // Mask is counted even when saturation wins the colour.
                     if (in_msk && !(&mask_acc))
                        mask_acc <= mask_acc + 1'b1;
                     if (in_sat && !(&sat_acc))
                        sat_acc <= sat_acc + 1'b1;
                     if (s_axis_tlast && !(&line_acc))
                        line_acc <= line_acc + 1'b1;
                  end
               end
            end
            default: state <= WAIT_SOF;
         endcase
      end
   end
`else
   assign mask_count  = '0;
   assign sat_count   = '0;
   assign line_count  = '0;
   assign stats_valid = 1'b0;
`endif

endmodule

// File: doc/hist_mask_overlay.md
# hist_mask_overlay

Downstream consumer of the histogram-equalisation mask stage. Takes its 24-bit AXI-Stream pixel ({saturation mask, contrast mask, original grey}) and renders an RGB preview, with saturated pixels in red and masked pixels tinted green. Buffers the result in a small FIFO so the display/VDMA sink can apply backpressure. Produces per-frame mask and saturation pixel counts for software.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per channel; input and output tdata are 3*DATA_WIDTH.
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥4.
- CNT_WIDTH, 24, width of the per-frame counters.

Ports:
- i_sys_clk  in  1  system clock, all logic rising-edge.
- i_sys_areset  in  1  asynchronous, active-high reset.
- en_overlay  in  1  1 = colour overlay, 0 = grey passthrough on all three channels.
- clear_overflow  in  1  synchronous one-cycle clear of `overflow`.
- s_axis_tdata  in  3*DATA_WIDTH  [23:16] saturation mask, [15:8] contrast mask, [7:0] grey.
- s_axis_tvalid / s_axis_tuser / s_axis_tlast  in  1 each  upstream stream qualifiers; tuser = first pixel of frame.
- s_axis_tready  out  1  ~fifo_full. Upstream does not honour it; loss is flagged instead.
- m_axis_tdata  out  3*DATA_WIDTH  {R,G,B}.
- m_axis_tvalid / m_axis_tuser / m_axis_tlast  out  1 each.
- m_axis_tready  in  1  downstream backpressure.
- mask_count  out  CNT_WIDTH  contrast-mask pixels of the last completed frame.
- sat_count  out  CNT_WIDTH  saturated pixels of the last completed frame.
- line_count  out  16  tlast beats of the last completed frame.
- stats_valid  out  1  one-cycle pulse when the three counts update.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.

## Operation
- Colour stage (one register):
  - sat = tdata[23:16] == all-ones; msk = tdata[15:8] == all-ones; g = tdata[7:0].
  - With en_overlay=1:
    - sat → {FF,00,00}.
    - msk and not sat → {g>>1, 8'h80 + (g>>1), g>>1}. The sum cannot overflow.
    - Otherwise → {g,g,g}.
  - With en_overlay=0: always {g,g,g}.
  - tuser and tlast travel with the pixel. Stage output valid = registered s_axis_tvalid.
- FIFO: synchronous, FIFO_DEPTH × (3*DATA_WIDTH+2), first-word-fall-through.
  - Write when the stage output is valid and the FIFO is not full.
  - Valid while full: the pixel is dropped and `overflow` is set.
  - Read when m_axis_tvalid && m_axis_tready.
  - Simultaneous read and write while full: the read frees a slot, so the write is accepted and there is no overflow.
  - Pointers wrap modulo FIFO_DEPTH. The count distinguishes full from empty.
- `overflow`: set has priority over clear_overflow in the same cycle.
- Stats FSM, states WAIT_SOF and IN_FRAME. Operates on colour-stage-input pixels and is independent of FIFO drops.
  - WAIT_SOF:
    - Ignore pixels until tvalid && tuser.
    - On that pixel, load counters with that pixel's contributions (mask/sat = 0 or 1; lines = tlast) and go to IN_FRAME. No stats_valid.
  - IN_FRAME, valid non-tuser pixel: mask_acc += msk, sat_acc += sat, line_acc += tlast.
    - Each accumulator saturates at all-ones.
    - sat and msk both set → both counted. The mask count is independent of the colour priority.
  - IN_FRAME, valid tuser pixel:
    - Copy the accumulators to the output registers and pulse stats_valid.
    - Reload the accumulators with the current pixel's contributions. Stay in IN_FRAME.
- Reset (any time, including mid-frame or with the FIFO non-empty):
  - FIFO emptied, FSM → WAIT_SOF, accumulators cleared.
  - Outputs at reset: m_axis_tdata 0, m_axis_tvalid 0, m_axis_tuser 0, m_axis_tlast 0.
  - Outputs at reset: s_axis_tready 0, mask_count/sat_count/line_count 0, stats_valid 0, overflow 0.
  - s_axis_tready rises the first cycle after reset deasserts.

## Timing
- Latency with the FIFO empty and m_axis_tready=1: input at edge N → m_axis_tvalid with data after edge N+2 (colour register + FIFO write).
- m_axis_tdata/tuser/tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Sustained throughput: 1 pixel/cycle when m_axis_tready=1.
- stats_valid rises in the cycle after the clock edge that samples the new-frame tuser pixel. The counts are valid from that same cycle and held until the next update.
- s_axis_tready drops in the cycle the FIFO becomes full.

## Configuration
- HIST_OVERLAY_STATS_EN defined: stats FSM, accumulators and count outputs are present as described.
- HIST_OVERLAY_STATS_EN undefined: none of that logic is built. mask_count, sat_count, line_count and stats_valid are tied to 0. The overlay and FIFO are unchanged.

## Test plan
- Overlay mapping, en_overlay=1, m_axis_tready=1: inputs 0xFF0040, 0x00FF40, 0xFFFF40, 0x000040 → outputs 0xFF0000, 0x20A020, 0xFF0000, 0x404040, each 2 cycles after its input.
- Passthrough: en_overlay=0, input 0xFFFF7F → 0x7F7F7F.
- Stats (macro defined):
  - Frame A: 4×4, 3 mask-only pixels, 2 sat-only pixels, tlast every 4th pixel. Then the tuser pixel of frame B.
  - Required: a single stats_valid pulse with mask_count=3, sat_count=2, line_count=4. No pulse at frame A's own tuser.
- Backpressure/overflow, FIFO_DEPTH=16:
  - Hold m_axis_tready=0 and stream 20 valid pixels.
  - Required: s_axis_tready=0 after FIFO fill; overflow=1 after pixel 17.
  - Then release m_axis_tready: exactly the first 16 pixels emerge in order.
- Full + simultaneous read/write: FIFO full, m_axis_tready=1 and a valid input in the same cycle → the pixel is accepted, overflow stays 0.
- Reset mid-frame with 5 FIFO entries:
  - Assert i_sys_areset asynchronously → m_axis_tvalid=0 and all counts 0 immediately.
  - After release, a frame without a leading tuser produces no stats_valid.
